// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage types and constants.
// Opcode values are also used by the control decoder.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    ISSUE,
    FAULT
  } fetch_state_e;

  localparam int unsigned INSTR_BYTES = 4;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC selection: sequential or branch target.
// Flags targets that are not word aligned.
module fetch_next_pc (
  input  logic [31:0] pc_i,
  input  logic [31:0] off_i,
  input  logic        pcsrc_i,
  output logic [31:0] next_o,
  output logic        misaligned_o
);
  import fetch_unit_pkg::*;

  assign next_o = pcsrc_i ? pc_i + off_i
                          : pc_i + 32'(INSTR_BYTES);

  assign misaligned_o = |next_o[1:0];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, req/ack memory port,
// instruction register, retire counter, misalign trap.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemAck,
  input  logic [31:0] IMemData,
  output logic [31:0] Instr,
  output logic [6:0]  OP,
  output logic [31:0] PC,
  output logic        InstrValid,
  input  logic        InstrReady,
  input  logic        PCsrc,
  input  logic [31:0] BranchOff,
  output logic        FetchFault,
  output logic [31:0] RetireCount
);
  import fetch_unit_pkg::*;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  cnt_q, cnt_d;
  logic         valid_q, valid_d;
  logic         fault_q, fault_d;
  logic [31:0]  next_pc;
  logic         misaligned;

  fetch_next_pc u_next_pc (
    .pc_i         (pc_q),
    .off_i        (BranchOff),
    .pcsrc_i      (PCsrc),
    .next_o       (next_pc),
    .misaligned_o (misaligned)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    fault_d = fault_q;
    unique case (state_q)
      BOOT: state_d = FETCH;
      FETCH: begin
        if (IMemAck) begin
          instr_d = IMemData;
          valid_d = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (InstrReady) begin
          valid_d = 1'b0;
          cnt_d   = cnt_q + 32'd1;
          // faulting instruction still retires
          if (misaligned) begin
            fault_d = 1'b1;
            state_d = FAULT;
          end else begin
            pc_d    = next_pc;
            state_d = FETCH;
          end
        end
      end
      FAULT: valid_d = 1'b0;
      default: state_d = BOOT;
    endcase
  end

  assign IMemReq     = (state_q == FETCH);
  assign IMemAddr    = pc_q;
  assign Instr       = instr_q;
  assign OP          = instr_q[6:0];
  assign PC          = pc_q;
  assign InstrValid  = valid_q;
  assign FetchFault  = fault_q;
  assign RetireCount = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit with a
// behavioural PC/retire model and random stimulus.
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemAck = 1'b0;
  logic [31:0] IMemData = '0;
  logic [31:0] Instr;
  logic [6:0]  OP;
  logic [31:0] PC;
  logic        InstrValid;
  logic        InstrReady = 1'b0;
  logic        PCsrc = 1'b0;
  logic [31:0] BranchOff = '0;
  logic        FetchFault;
  logic [31:0] RetireCount;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  logic        m_fault;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RPC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .IMemReq     (IMemReq),
    .IMemAddr    (IMemAddr),
    .IMemAck     (IMemAck),
    .IMemData    (IMemData),
    .Instr       (Instr),
    .OP          (OP),
    .PC          (PC),
    .InstrValid  (InstrValid),
    .InstrReady  (InstrReady),
    .PCsrc       (PCsrc),
    .BranchOff   (BranchOff),
    .FetchFault  (FetchFault),
    .RetireCount (RetireCount)
  );

  task automatic do_reset();
    rst_n = 1'b0;
    IMemAck = 1'b0;
    IMemData = '0;
    InstrReady = 1'b0;
    PCsrc = 1'b0;
    BranchOff = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_pc = RPC;
    m_cnt = '0;
    m_fault = 1'b0;
  endtask

  // Memory side: wait for a request, delay, then ack.
  task automatic mem_fetch(input int dly,
                           input logic [31:0] data,
                           output bit ok,
                           output bit stable,
                           output logic [31:0] addr);
    stable = 1'b1;
    addr = 'x;
    for (int i = 0; i < 20 && IMemReq !== 1'b1; i++)
      @(negedge clk);
    ok = (IMemReq === 1'b1);
    if (!ok) return;
    addr = IMemAddr;
    repeat (dly) begin
      InstrReady = 1'($urandom);
      @(negedge clk);
      if (IMemReq !== 1'b1 || IMemAddr !== addr)
        stable = 1'b0;
    end
    InstrReady = 1'($urandom);
    IMemAck = 1'b1;
    IMemData = data;
    @(negedge clk);
    IMemAck = 1'b0;
    IMemData = $urandom;
    InstrReady = 1'b0;
  endtask

  // Decoder side: stall, then accept; updates the model.
  task automatic accept(input int hold,
                        input logic src,
                        input logic [31:0] off,
                        output bit held);
    logic [31:0] i0, p0, c0, nx;
    i0 = Instr;
    p0 = PC;
    c0 = RetireCount;
    held = 1'b1;
    repeat (hold) begin
      InstrReady = 1'b0;
      IMemAck = 1'($urandom);
      IMemData = $urandom;
      PCsrc = 1'($urandom);
      @(negedge clk);
      if (Instr !== i0 || PC !== p0 ||
          RetireCount !== c0 || IMemReq !== 1'b0 ||
          InstrValid !== 1'b1)
        held = 1'b0;
    end
    IMemAck = 1'b0;
    PCsrc = src;
    BranchOff = off;
    InstrReady = 1'b1;
    @(negedge clk);
    InstrReady = 1'b0;
    PCsrc = 1'b0;
    nx = src ? m_pc + off : m_pc + 32'd4;
    m_cnt = m_cnt + 32'd1;
    if (nx[1:0] != 2'b00) m_fault = 1'b1;
    else m_pc = nx;
  endtask

  task automatic test_reset();
    bit ok, st, hd;
    logic [31:0] a, d;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (IMemReq !== 1'b0 || PC !== RPC || Instr !== 0 ||
        OP !== 0 || InstrValid !== 1'b0 ||
        FetchFault !== 1'b0 || RetireCount !== 0) begin
      miscompares++;
      $display("FAIL reset_vals: req=%b pc=%h ins=%h v=%b f=%b cnt=%0d",
               IMemReq, PC, Instr, InstrValid, FetchFault, RetireCount);
    end
    rst_n = 1'b1;
    m_pc = RPC; m_cnt = 0; m_fault = 0;
    vectors++;
    if (IMemReq !== 1'b0) begin
      miscompares++;
      $display("FAIL boot_req: got %b want 0", IMemReq);
    end
    @(negedge clk);
    vectors++;
    if (IMemReq !== 1'b1 || IMemAddr !== RPC) begin
      miscompares++;
      $display("FAIL first_req: req=%b addr=%h want 1 %h",
               IMemReq, IMemAddr, RPC);
    end
    d = 32'hDEAD_BE33;
    mem_fetch(0, d, ok, st, a);
    vectors++;
    if (!ok || Instr !== d || OP !== d[6:0] ||
        InstrValid !== 1'b1 || IMemReq !== 1'b0) begin
      miscompares++;
      $display("FAIL lat0_fetch: ins=%h op=%h v=%b req=%b want %h",
               Instr, OP, InstrValid, IMemReq, d);
    end
    accept(0, 1'b0, 32'h0, hd);
    vectors++;
    if (IMemReq !== 1'b1 || IMemAddr !== m_pc ||
        RetireCount !== m_cnt || InstrValid !== 1'b0) begin
      miscompares++;
      $display("FAIL first_accept: req=%b addr=%h cnt=%0d want %h %0d",
               IMemReq, IMemAddr, RetireCount, m_pc, m_cnt);
    end
  endtask

  task automatic test_sequential();
    bit ok, st, hd;
    logic [31:0] a, d;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      d = $urandom;
      mem_fetch(3, d, ok, st, a);
      vectors++;
      if (!ok || !st || a !== RPC + 32'(4 * k) ||
          Instr !== d || PC !== a) begin
        miscompares++;
        $display("FAIL seq_fetch%0d: ok=%b stable=%b addr=%h ins=%h want %h %h",
                 k, ok, st, a, Instr, RPC + 32'(4 * k), d);
      end
      accept(0, 1'b0, 32'h0, hd);
    end
    vectors++;
    if (RetireCount !== 32'd3 || IMemAddr !== 32'h10C) begin
      miscompares++;
      $display("FAIL seq_count: cnt=%0d addr=%h want 3 10c",
               RetireCount, IMemAddr);
    end
  endtask

  task automatic test_branch();
    bit ok, st, hd;
    logic [31:0] a;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      mem_fetch(1, $urandom, ok, st, a);
      accept(0, 1'b0, 32'h0, hd);
    end
    mem_fetch(0, $urandom, ok, st, a);
    accept(0, 1'b1, 32'hFFFF_FFF8, hd);
    vectors++;
    if (IMemReq !== 1'b1 || IMemAddr !== 32'h100) begin
      miscompares++;
      $display("FAIL branch_back: addr=%h req=%b want 100",
               IMemAddr, IMemReq);
    end
    for (int k = 0; k < 2; k++) begin
      mem_fetch(0, $urandom, ok, st, a);
      accept(0, 1'b0, 32'h0, hd);
    end
    mem_fetch(2, $urandom, ok, st, a);
    vectors++;
    if (a !== 32'h108) begin
      miscompares++;
      $display("FAIL branch_refetch: addr=%h want 108", a);
    end
    accept(0, 1'b0, 32'hFFFF_FFF8, hd);
    vectors++;
    if (IMemAddr !== 32'h10C || RetireCount !== m_cnt) begin
      miscompares++;
      $display("FAIL branch_notaken: addr=%h cnt=%0d want 10c %0d",
               IMemAddr, RetireCount, m_cnt);
    end
  endtask

  task automatic test_backpressure();
    bit ok, st, hd;
    logic [31:0] a;
    do_reset();
    mem_fetch(1, $urandom, ok, st, a);
    accept(5, 1'b0, 32'h0, hd);
    vectors++;
    if (!hd) begin
      miscompares++;
      $display("FAIL backpressure_hold: held=%b want 1", hd);
    end
    vectors++;
    if (RetireCount !== 32'd1 || IMemAddr !== 32'h104) begin
      miscompares++;
      $display("FAIL backpressure_accept: cnt=%0d addr=%h want 1 104",
               RetireCount, IMemAddr);
    end
  endtask

  task automatic test_misaligned();
    bit ok, st, hd, quiet;
    logic [31:0] a;
    do_reset();
    mem_fetch(0, $urandom, ok, st, a);
    accept(0, 1'b1, 32'h2, hd);
    vectors++;
    if (FetchFault !== 1'b1 || PC !== RPC || IMemReq !== 1'b0 ||
        RetireCount !== 32'd1 || InstrValid !== 1'b0) begin
      miscompares++;
      $display("FAIL misalign_trap: f=%b pc=%h req=%b cnt=%0d v=%b",
               FetchFault, PC, IMemReq, RetireCount, InstrValid);
    end
    quiet = 1'b1;
    repeat (12) begin
      IMemAck = 1'($urandom);
      InstrReady = 1'($urandom);
      PCsrc = 1'($urandom);
      @(negedge clk);
      if (IMemReq !== 1'b0 || FetchFault !== 1'b1 ||
          RetireCount !== 32'd1 || PC !== RPC ||
          InstrValid !== 1'b0)
        quiet = 1'b0;
    end
    IMemAck = 1'b0;
    InstrReady = 1'b0;
    vectors++;
    if (!quiet) begin
      miscompares++;
      $display("FAIL misalign_sticky: quiet=%b want 1", quiet);
    end
  endtask

  task automatic test_reset_midfetch();
    bit ok, st, hd;
    logic [31:0] a, d;
    do_reset();
    mem_fetch(0, $urandom, ok, st, a);
    accept(0, 1'b0, 32'h0, hd);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (PC !== RPC || IMemReq !== 1'b0 || RetireCount !== 0) begin
      miscompares++;
      $display("FAIL async_reset: pc=%h req=%b cnt=%0d want %h 0 0",
               PC, IMemReq, RetireCount, RPC);
    end
    IMemAck = 1'b1;
    IMemData = 32'hBAD0_0BAD;
    @(negedge clk);
    rst_n = 1'b1;
    m_pc = RPC; m_cnt = 0; m_fault = 0;
    @(negedge clk);
    vectors++;
    if (InstrValid !== 1'b0 || Instr !== 0 ||
        IMemReq !== 1'b1 || IMemAddr !== RPC) begin
      miscompares++;
      $display("FAIL stale_ack: v=%b ins=%h req=%b addr=%h",
               InstrValid, Instr, IMemReq, IMemAddr);
    end
    IMemAck = 1'b0;
    d = $urandom;
    mem_fetch(1, d, ok, st, a);
    vectors++;
    if (!ok || Instr !== d || a !== RPC) begin
      miscompares++;
      $display("FAIL post_reset_fetch: ins=%h addr=%h want %h %h",
               Instr, a, d, RPC);
    end
  endtask

  task automatic test_wrap();
    bit ok, st, hd;
    logic [31:0] a;
    do_reset();
    mem_fetch(0, $urandom, ok, st, a);
    accept(0, 1'b1, 32'hFFFF_FFFC - RPC, hd);
    vectors++;
    if (IMemAddr !== 32'hFFFF_FFFC) begin
      miscompares++;
      $display("FAIL wrap_target: addr=%h want fffffffc", IMemAddr);
    end
    mem_fetch(0, $urandom, ok, st, a);
    accept(1, 1'b0, 32'h0, hd);
    vectors++;
    if (IMemAddr !== 32'h0 || IMemReq !== 1'b1 ||
        FetchFault !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_pc4: addr=%h req=%b f=%b want 0 1 0",
               IMemAddr, IMemReq, FetchFault);
    end
  endtask

  task automatic test_random();
    bit ok, st, hd, src;
    logic [31:0] a, d, off;
    int so;
    do_reset();
    for (int n = 0; n < 150; n++) begin
      if (m_fault) do_reset();
      d = $urandom;
      mem_fetch($urandom_range(0, 3), d, ok, st, a);
      vectors++;
      if (!ok || !st || a !== m_pc || Instr !== d ||
          OP !== d[6:0] || PC !== m_pc || InstrValid !== 1'b1) begin
        miscompares++;
        $display("FAIL rnd_fetch%0d: ok=%b st=%b addr=%h ins=%h want %h %h",
                 n, ok, st, a, Instr, m_pc, d);
        do_reset();
        continue;
      end
      src = 1'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        off = $urandom;
      end else begin
        so = int'($urandom_range(0, 64)) - 32;
        off = 32'(so * 4);
      end
      accept($urandom_range(0, 2), src, off, hd);
      vectors++;
      if (!hd || RetireCount !== m_cnt ||
          FetchFault !== m_fault || IMemReq !== !m_fault ||
          PC !== m_pc) begin
        miscompares++;
        $display("FAIL rnd_accept%0d: cnt=%0d f=%b req=%b pc=%h want %0d %b %h",
                 n, RetireCount, FetchFault, IMemReq, PC,
                 m_cnt, m_fault, m_pc);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_sequential();
    test_branch();
    test_backpressure();
    test_misaligned();
    test_reset_midfetch();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
